// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads and buffers responses
// in a DEPTH-entry prefetch queue for decode. Optional FETCH_PERF_EN adds stall/flush counters.
module fetch_queue #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [PC_WIDTH-1:0]    pc_inced_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            stall_cnt_o,
    output logic [31:0]            flush_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       FULL = CW'(DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0]    pc_reg;
    logic [PC_WIDTH-1:0]    issued_pc_reg;
    logic                   inflight_reg;
    logic [CW-1:0]          count_reg;
    logic [PW-1:0]          wr_ptr_reg;
    logic [PW-1:0]          rd_ptr_reg;
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] used;

    // Credits count both stored entries and the response still on its way.
    assign used  = count_reg + {{(CW-1){1'b0}}, inflight_reg};
    assign issue = !rst_i && !redirect_i && (used < FULL);
    assign push  = inflight_reg && !redirect_i;
    assign pop   = valid_o && ready_i && !redirect_i;

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_reg;
    assign valid_o     = (count_reg != '0);
    assign instr_o     = instr_mem[rd_ptr_reg];
    assign pc_o        = pc_mem[rd_ptr_reg];
    assign pc_inced_o  = pc_mem[rd_ptr_reg] + STEP;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_reg        <= RESET_PC;
            issued_pc_reg <= '0;
            inflight_reg  <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else if (redirect_i) begin
            // Clearing inflight also drops the response due next cycle.
            pc_reg       <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg        <= pc_reg + STEP;
                issued_pc_reg <= pc_reg;
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rdata_i;
            pc_mem[wr_ptr_reg]    <= issued_pc_reg;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (valid_o && !ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (redirect_i && flush_cnt_o != '1)          flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem model returns addr>>2; a second instance
// with RESET_PC=0xFFF8 covers PC wrap.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_req2;
    logic [15:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        valid, valid2;
    logic        ready;
    logic [31:0] instr, instr2;
    logic [15:0] pc, pc2, pc_inced, pc_inced2;
    logic        redirect2 = 1'b0;
    logic [15:0] redirect_pc2 = 16'h0;
    logic        ready2 = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif
    int total = 0;
    int bad = 0;
    int nreq;

    logic [15:0] w_pc  [5] = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004, 16'h0008};
    logic [15:0] w_inc [5] = '{16'hFFFC, 16'h0000, 16'h0004, 16'h0008, 16'h000C};
    logic [31:0] w_ins [5] = '{32'h3FFE, 32'h3FFF, 32'h0, 32'h1, 32'h2};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= 32'(imem_addr >> 2);
        if (imem_req2) imem_rdata2 <= 32'(imem_addr2 >> 2);
    end

    fetch_queue #(.PC_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk_i(clk), .rst_i(rst), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc), .pc_inced_o(pc_inced)
`ifdef FETCH_PERF_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    fetch_queue #(.PC_WIDTH(16), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(16'hFFF8)) dut2 (
        .clk_i(clk), .rst_i(rst), .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
        .imem_rdata_i(imem_rdata2), .redirect_i(redirect2), .redirect_pc_i(redirect_pc2),
        .valid_o(valid2), .ready_i(ready2), .instr_o(instr2), .pc_o(pc2), .pc_inced_o(pc_inced2)
`ifdef FETCH_PERF_EN
        , .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs for the next cycle, then settle before sampling.
    task automatic next(input logic rdy, input logic redir, input logic [15:0] rpc);
        @(negedge clk);
        ready = rdy; redirect = redir; redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        // Test 1 + 5: streaming from reset, plus wrap on dut2
        do_reset();
`ifdef FETCH_PERF_EN
        chk("perf_rst_stall", stall_cnt, 32'd0);
        chk("perf_rst_flush", flush_cnt, 32'd0);
`endif
        chk("t1_req_c1", 32'(imem_req), 32'd1);
        chk("t1_addr_c1", 32'(imem_addr), 32'h0);
        chk("t1_valid_c1", 32'(valid), 32'd0);
        next(1'b1, 1'b0, 16'h0);
        chk("t1_valid_c2", 32'(valid), 32'd0);
        chk("t1_addr_c2", 32'(imem_addr), 32'h4);
        for (int i = 0; i < 5; i++) begin
            next(1'b1, 1'b0, 16'h0);
            chk("t1_valid", 32'(valid), 32'd1);
            chk("t1_pc", 32'(pc), 32'(i * 4));
            chk("t1_instr", instr, 32'(i));
            chk("t5_valid", 32'(valid2), 32'd1);
            chk("t5_pc", 32'(pc2), 32'(w_pc[i]));
            chk("t5_pc_inced", 32'(pc_inced2), 32'(w_inc[i]));
            chk("t5_instr", instr2, w_ins[i]);
            $display("stream cycle %0d: pc=%h instr=%h wrap_pc=%h", i + 3, pc, instr, pc2);
        end

        // Test 2: stall from cycle 3, mid-operation reset first
        do_reset();
        nreq = int'(imem_req);
        next(1'b1, 1'b0, 16'h0);
        nreq += int'(imem_req);
        for (int i = 0; i < 6; i++) begin
            next(1'b0, 1'b0, 16'h0);
            nreq += int'(imem_req);
            chk("t2_hold_valid", 32'(valid), 32'd1);
            chk("t2_hold_pc", 32'(pc), 32'h0);
        end
        chk("t2_req_total", 32'(nreq), 32'd4);
        chk("t2_req_off", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            next(1'b1, 1'b0, 16'h0);
            chk("t2_valid", 32'(valid), 32'd1);
            chk("t2_pc", 32'(pc), 32'(i * 4));
            chk("t2_instr", instr, 32'(i));
            $display("release cycle %0d: pc=%h instr=%h", i, pc, instr);
        end

        // Test 3: redirect while the queue is full
        for (int i = 0; i < 6; i++) next(1'b0, 1'b0, 16'h0);
        chk("t3_full_req", 32'(imem_req), 32'd0);
        chk("t3_full_valid", 32'(valid), 32'd1);
        next(1'b1, 1'b1, 16'h0103);
        chk("t3_redir_req", 32'(imem_req), 32'd0);
        next(1'b1, 1'b0, 16'h0);
        chk("t3_valid_r1", 32'(valid), 32'd0);
        chk("t3_req_r1", 32'(imem_req), 32'd1);
        chk("t3_addr_r1", 32'(imem_addr), 32'h0100);
        next(1'b1, 1'b0, 16'h0);
        chk("t3_valid_r2", 32'(valid), 32'd0);
        chk("t3_addr_r2", 32'(imem_addr), 32'h0104);
        for (int i = 0; i < 4; i++) begin
            next(1'b1, 1'b0, 16'h0);
            chk("t3_valid", 32'(valid), 32'd1);
            chk("t3_pc", 32'(pc), 32'(16'h0100 + 16'(i * 4)));
            chk("t3_instr", instr, 32'(32'h40 + i));
            $display("after redirect %0d: pc=%h instr=%h", i, pc, instr);
        end

        // Test 4: redirect on a response cycle, then a second redirect right after
        next(1'b1, 1'b1, 16'h0200);
        chk("t4_redir1_req", 32'(imem_req), 32'd0);
        next(1'b1, 1'b1, 16'h0300);
        chk("t4_redir2_req", 32'(imem_req), 32'd0);
        chk("t4_redir2_valid", 32'(valid), 32'd0);
        next(1'b1, 1'b0, 16'h0);
        chk("t4_valid_a", 32'(valid), 32'd0);
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_addr", 32'(imem_addr), 32'h0300);
        next(1'b1, 1'b0, 16'h0);
        chk("t4_valid_b", 32'(valid), 32'd0);
        next(1'b1, 1'b0, 16'h0);
        chk("t4_valid_c", 32'(valid), 32'd1);
        chk("t4_pc", 32'(pc), 32'h0300);
        chk("t4_instr", instr, 32'hC0);
        next(1'b1, 1'b0, 16'h0);
        chk("t4_pc_next", 32'(pc), 32'h0304);
        chk("t4_pc_inced", 32'(pc_inced), 32'h0308);
        $display("double redirect: pc=%h", pc);

`ifdef FETCH_PERF_EN
        // Test 6: 5 stall cycles and 2 redirects
        do_reset();
        chk("perf_stall0", stall_cnt, 32'd0);
        chk("perf_flush0", flush_cnt, 32'd0);
        next(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            next(1'b0, 1'b0, 16'h0);
            chk("perf_stall_valid", 32'(valid), 32'd1);
        end
        next(1'b1, 1'b0, 16'h0);
        next(1'b1, 1'b0, 16'h0);
        next(1'b1, 1'b1, 16'h0040);
        next(1'b1, 1'b1, 16'h0080);
        next(1'b1, 1'b0, 16'h0);
        chk("perf_stall_cnt", stall_cnt, 32'd5);
        chk("perf_flush_cnt", flush_cnt, 32'd2);
        $display("perf: stall=%0d flush=%0d", stall_cnt, flush_cnt);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
